// File: rtl/column_scanner.sv
// Column scanner driving a 74HC595 chain: one select word per column,
// shifted MSB first, latched with STCP, with /OE gating after startup.
module column_scanner #(
  parameter int NUM_COLUMNS       = 8,
  parameter int STEP_BITS         = 8,
  parameter int EXTRA_BITS        = 1,
  parameter int CLK_DIV           = 1,
  parameter int BLANK_CYCLES      = 0,
  parameter int ENABLE_DELAY      = 2,
  parameter int SELECT_ACTIVE_LOW = 1,
  localparam int CW = $clog2(NUM_COLUMNS + 1),
  localparam int EW = (EXTRA_BITS > 0) ? EXTRA_BITS : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_index,
  input  logic [EW-1:0] extra_bits,
  input  logic          output_enable,
  output logic          ready,
  output logic [CW-1:0] cur_column,
  output logic          ser_clk,
  output logic          ser_data,
  output logic          ser_stcp,
  output logic          ser_n_enable
);

  localparam int TMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = (STEP_BITS > 1) ? $clog2(STEP_BITS) : 1;
  localparam int NW = (ENABLE_DELAY > 0) ? $clog2(ENABLE_DELAY + 1) : 1;
  localparam logic [EW-1:0] EXM = (EXTRA_BITS > 0) ? {EW{1'b1}} : '0;

  localparam logic [1:0] OP_NEXT  = 2'b00;
  localparam logic [1:0] OP_FIRST = 2'b01;
  localparam logic [1:0] OP_GOTO  = 2'b10;
  // OP_CLR doubles as the startup clear frame; NOP never reaches op_q
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_LO, S_HI, S_LATCH, S_BLANK
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [EW-1:0]  ext_q, ext_d;
  logic [CW-1:0]  col_q, col_d;
  logic [STEP_BITS-1:0] sh_q, sh_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [CW-1:0]  cur_q, cur_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic           arm_q, arm_d;
  logic           nen_q, nen_d;

  logic           tmr_end, last_word, act_w, act_nx;
  logic [CW-1:0]  col_nx;
  logic [EW-1:0]  ex_w;

  function automatic logic [STEP_BITS-1:0] word_f(
    input logic act, input logic [EW-1:0] ex);
    logic sel;
    sel = (SELECT_ACTIVE_LOW != 0) ? ~act : act;
    return (STEP_BITS'(ex & EXM) << 1) | STEP_BITS'(sel);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      op_q    <= OP_CLR;
      idx_q   <= '0;
      ext_q   <= '0;
      col_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      cur_q   <= CW'(NUM_COLUMNS);
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      nen_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      ext_q   <= ext_d;
      col_q   <= col_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      nen_q   <= nen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    ext_d   = ext_q;
    col_d   = col_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    tmr_d   = tmr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    tmr_end   = (tmr_q == TW'(CLK_DIV - 1));
    last_word = !op_q[1] || (col_q == '0);
    col_nx    = col_q - 1'b1;
    ex_w      = (op_q == OP_CLR) ? '0 : ext_q;
    act_w     = (op_q == OP_FIRST) ||
                (op_q == OP_GOTO && col_q == idx_q);
    act_nx    = (op_q == OP_GOTO && col_nx == idx_q);
    unique case (state_q)
      S_INIT: begin
        op_d    = OP_CLR;
        col_d   = CW'(NUM_COLUMNS - 1);
        sh_d    = word_f(1'b0, '0);
        bit_d   = '0;
        tmr_d   = '0;
        state_d = S_LO;
      end
      S_IDLE: begin
        if (cmd_valid && cmd_op != OP_CLR) begin
          op_d    = cmd_op;
          idx_d   = cmd_index;
          ext_d   = extra_bits;
          col_d   = cmd_op[1] ? CW'(NUM_COLUMNS - 1) : '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sh_d    = word_f(act_w, ex_w);
        bit_d   = '0;
        tmr_d   = '0;
        state_d = S_LO;
      end
      S_LO: begin
        if (tmr_end) begin
          tmr_d   = '0;
          state_d = S_HI;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_HI: begin
        if (!tmr_end) begin
          tmr_d = tmr_q + 1'b1;
        end else begin
          tmr_d = '0;
          if (bit_q != BW'(STEP_BITS - 1)) begin
            sh_d    = sh_q << 1;
            bit_d   = bit_q + 1'b1;
            state_d = S_LO;
          end else if (!last_word) begin
            col_d   = col_nx;
            sh_d    = word_f(act_nx, ex_w);
            bit_d   = '0;
            state_d = S_LO;
          end else begin
            state_d = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (!tmr_end) begin
          tmr_d = tmr_q + 1'b1;
        end else begin
          tmr_d   = '0;
          state_d = (BLANK_CYCLES > 0) ? S_BLANK : S_IDLE;
          unique case (op_q)
            OP_NEXT:
              if (cur_q != CW'(NUM_COLUMNS)) cur_d = cur_q + 1'b1;
            OP_FIRST: cur_d = '0;
            OP_GOTO:
              cur_d = (idx_q < CW'(NUM_COLUMNS)) ? idx_q
                                                 : CW'(NUM_COLUMNS);
            default: cur_d = CW'(NUM_COLUMNS);
          endcase
          // startup frames count up first; the next one arms /OE
          if (op_q == OP_FIRST || op_q == OP_GOTO) begin
            if (cnt_q == NW'(ENABLE_DELAY)) arm_d = 1'b1;
            else cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_BLANK: begin
        if (tmr_q == TW'(BLANK_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
    nen_d = !(arm_d && output_enable &&
              !(state_d inside {S_INIT, S_LATCH, S_BLANK}));
  end

  always_comb begin
    ready        = (state_q == S_IDLE);
    ser_clk      = (state_q == S_HI);
    ser_stcp     = (state_q == S_LATCH);
    ser_data     = (state_q == S_LO || state_q == S_HI) &&
                   sh_q[STEP_BITS-1];
    cur_column   = cur_q;
    ser_n_enable = nen_q;
  end

endmodule
